// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-stream arbiter family: FSM state codes and sizing helpers.
package axis_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // A single requester still needs a one-bit index.
    function automatic int src_width(input int ports);
        return (ports < 2) ? 1 : clog2(ports);
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set request bit searching cyclically from last+1.
module axis_rr_pick
    import axis_pkg::*;
#(
    parameter int PORTS     = 4,
    parameter int SRC_WIDTH = src_width(PORTS)
) (
    input  logic [PORTS-1:0]     req,
    input  logic [SRC_WIDTH-1:0] last,
    output logic                 any,
    output logic [SRC_WIDTH-1:0] winner
);

    // Scan from the farthest offset down so the nearest requester overwrites the rest.
    always_comb begin
        logic [SRC_WIDTH-1:0] cand;
        any    = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = PORTS; off >= 1; off--) begin
            cand = SRC_WIDTH'((int'(last) + off) % PORTS);
            if (req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-stream arbiter with a fully registered output slot.
// Define AXIS_ARB_LAST_EN to hold grants for whole packets (ilast/olast) instead of bursts.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int SRC_WIDTH  = src_width(PORTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PORTS*DATA_WIDTH-1:0] idata,
    input  logic [PORTS-1:0]            ivalid,
`ifdef AXIS_ARB_LAST_EN
    input  logic [PORTS-1:0]            ilast,
    output logic                        olast,
`endif
    output logic [PORTS-1:0]            iready,
    output logic [DATA_WIDTH-1:0]       odata,
    output logic                        ovalid,
    input  logic                        oready,
    output logic [SRC_WIDTH-1:0]        osource,
    output logic                        busy
);

    localparam int                     BURST_WIDTH = clog2(MAX_BURST + 1);
    localparam logic [SRC_WIDTH-1:0]   LAST_RESET  = SRC_WIDTH'(PORTS - 1);
    localparam logic [BURST_WIDTH-1:0] BURST_MAX   = BURST_WIDTH'(MAX_BURST);

    state_t                 state_q, state_d;
    logic [SRC_WIDTH-1:0]   grant_q, grant_d;
    logic [SRC_WIDTH-1:0]   last_q, last_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [DATA_WIDTH-1:0]  odata_q, odata_d;
    logic                   ovalid_q, ovalid_d;
    logic [SRC_WIDTH-1:0]   osource_q, osource_d;
`ifdef AXIS_ARB_LAST_EN
    logic                   olast_q, olast_d;
`endif

    logic                   pickAny;
    logic [SRC_WIDTH-1:0]   pickWinner;
    logic                   canLoad;
    logic                   grantValid;
    logic                   inXfer;
    logic                   outXfer;
    logic                   releaseGrant;
    logic [BURST_WIDTH-1:0] burstInc;

    axis_rr_pick #(
        .PORTS     (PORTS),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .req    (ivalid),
        .last   (last_q),
        .any    (pickAny),
        .winner (pickWinner)
    );

    assign canLoad    = !ovalid_q || oready;
    assign grantValid = ivalid[grant_q];
    assign inXfer     = (state_q == GRANT) && canLoad && grantValid;
    assign outXfer    = ovalid_q && oready;
    assign burstInc   = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_WIDTH'(1);

`ifdef AXIS_ARB_LAST_EN
    assign releaseGrant = inXfer && ilast[grant_q];
`else
    // Back-pressure (!canLoad) never releases: only a full burst or an idle requester does.
    assign releaseGrant = (inXfer && (burstInc == BURST_MAX)) || (canLoad && !grantValid);
`endif

    always_comb begin
        iready = '0;
        if ((state_q == GRANT) && canLoad && !reset) iready[grant_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (state_q == IDLE) begin
            if (pickAny) begin
                grant_d = pickWinner;
                state_d = GRANT;
                burst_d = '0;
            end
        end else begin
            if (inXfer) burst_d = burstInc;
            if (releaseGrant) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
        end
    end

    always_comb begin
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;
        osource_d = osource_q;
`ifdef AXIS_ARB_LAST_EN
        olast_d   = olast_q;
`endif
        if (inXfer) begin
            odata_d   = idata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            osource_d = grant_q;
            ovalid_d  = 1'b1;
`ifdef AXIS_ARB_LAST_EN
            olast_d   = ilast[grant_q];
`endif
        end else if (outXfer) begin
            ovalid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= LAST_RESET;
            burst_q   <= '0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            osource_q <= '0;
`ifdef AXIS_ARB_LAST_EN
            olast_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            osource_q <= osource_d;
`ifdef AXIS_ARB_LAST_EN
            olast_q   <= olast_d;
`endif
        end
    end

    assign odata   = odata_q;
    assign ovalid  = ovalid_q;
    assign osource = osource_q;
    assign busy    = (state_q == GRANT);
`ifdef AXIS_ARB_LAST_EN
    assign olast   = olast_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed testbench for axis_rr_arbiter: per-scenario tasks with hand-computed expectations.
// Producer beats carry {port, sequence} so every delivered beat identifies its origin.
module tb_axis_rr_arbiter;

    localparam int PORTS      = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int SRC_WIDTH  = 2;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic [PORTS*DATA_WIDTH-1:0] idata = '0;
    logic [PORTS-1:0]            ivalid = '0;
    logic [PORTS-1:0]            iready;
    logic [DATA_WIDTH-1:0]       odata;
    logic                        ovalid;
    logic                        oready = 1'b1;
    logic [SRC_WIDTH-1:0]        osource;
    logic                        busy;
`ifdef AXIS_ARB_LAST_EN
    logic [PORTS-1:0]            ilast = '0;
    logic                        olast;
    logic                        outLast[$];
`endif

    int vectors     = 0;
    int miscompares = 0;

    // remaining < 0 means the port requests forever
    int remaining[PORTS];
    int seqCnt[PORTS];
    int accepted;
    int delivered;
    logic [SRC_WIDTH-1:0]  outSrc[$];
    logic [DATA_WIDTH-1:0] outData[$];

    always #5 clock = ~clock;

    axis_rr_arbiter #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .SRC_WIDTH  (SRC_WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .idata   (idata),
        .ivalid  (ivalid),
`ifdef AXIS_ARB_LAST_EN
        .ilast   (ilast),
        .olast   (olast),
`endif
        .iready  (iready),
        .odata   (odata),
        .ovalid  (ovalid),
        .oready  (oready),
        .osource (osource),
        .busy    (busy)
    );

    task automatic applyStimulus();
        for (int i = 0; i < PORTS; i++) begin
            ivalid[i] = (remaining[i] != 0);
            idata[i*DATA_WIDTH +: DATA_WIDTH] = 8'(i * 16 + seqCnt[i] % 16);
`ifdef AXIS_ARB_LAST_EN
            ilast[i] = (remaining[i] == 1);
`endif
        end
        #1;
    endtask

    // One clock: sample handshakes before the edge, advance the producer model after it.
    task automatic cycle();
        logic [PORTS-1:0] fire;
        applyStimulus();
        fire = ivalid & iready;
        if (ovalid && oready) begin
            outSrc.push_back(osource);
            outData.push_back(odata);
`ifdef AXIS_ARB_LAST_EN
            outLast.push_back(olast);
`endif
            delivered++;
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < PORTS; i++) begin
            if (fire[i]) begin
                seqCnt[i]++;
                accepted++;
                if (remaining[i] > 0) remaining[i]--;
            end
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < PORTS; i++) begin
            remaining[i] = 0;
            seqCnt[i]    = 0;
        end
        outSrc.delete();
        outData.delete();
`ifdef AXIS_ARB_LAST_EN
        outLast.delete();
`endif
        accepted  = 0;
        delivered = 0;
    endtask

    task automatic resetDut();
        reset  = 1'b1;
        oready = 1'b1;
        clearModel();
        applyStimulus();
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clearModel();
        reset = 1'b1;
        for (int i = 0; i < PORTS; i++) remaining[i] = -1;
        applyStimulus();
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        applyStimulus();
        vectors++; if (ovalid !== 1'b0) begin $display("[TB] FAIL reset_ovalid: got %b expected 0", ovalid); miscompares++; end
        vectors++; if (odata !== 8'h00) begin $display("[TB] FAIL reset_odata: got %h expected 00", odata); miscompares++; end
        vectors++; if (osource !== 2'd0) begin $display("[TB] FAIL reset_osource: got %0d expected 0", osource); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy: got %b expected 0", busy); miscompares++; end
        vectors++; if (iready !== 4'b0000) begin $display("[TB] FAIL reset_iready: got %b expected 0000", iready); miscompares++; end
        for (int i = 0; i < PORTS; i++) remaining[i] = 0;
        reset = 1'b0;
        cycle();
        vectors++; if (busy !== 1'b0) begin $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); miscompares++; end
    endtask

    task automatic test_single_port();
        resetDut();
        remaining[0] = 3;
        applyStimulus();
        vectors++; if (iready !== 4'b0000) begin $display("[TB] FAIL single_arb_iready: got %b expected 0000", iready); miscompares++; end
        cycle();
        applyStimulus();
        vectors++; if (iready !== 4'b0001) begin $display("[TB] FAIL single_grant_iready: got %b expected 0001", iready); miscompares++; end
        vectors++; if (busy !== 1'b1) begin $display("[TB] FAIL single_grant_busy: got %b expected 1", busy); miscompares++; end
        vectors++; if (ovalid !== 1'b0) begin $display("[TB] FAIL single_grant_ovalid: got %b expected 0", ovalid); miscompares++; end
        cycle();
        vectors++; if (ovalid !== 1'b1) begin $display("[TB] FAIL single_first_ovalid: got %b expected 1", ovalid); miscompares++; end
        vectors++; if (odata !== 8'h00) begin $display("[TB] FAIL single_first_odata: got %h expected 00", odata); miscompares++; end
        vectors++; if (osource !== 2'd0) begin $display("[TB] FAIL single_first_osource: got %0d expected 0", osource); miscompares++; end
        cycle();
        cycle();
        vectors++; if (odata !== 8'h02) begin $display("[TB] FAIL single_last_odata: got %h expected 02", odata); miscompares++; end
        vectors++; if (busy !== 1'b1) begin $display("[TB] FAIL single_last_busy: got %b expected 1", busy); miscompares++; end
        cycle();
        vectors++; if (busy !== 1'b0) begin $display("[TB] FAIL single_release_busy: got %b expected 0", busy); miscompares++; end
        vectors++; if (ovalid !== 1'b0) begin $display("[TB] FAIL single_drain_ovalid: got %b expected 0", ovalid); miscompares++; end
        vectors++; if (outData.size() != 3) begin $display("[TB] FAIL single_count: got %0d expected 3", outData.size()); miscompares++; end
    endtask

    task automatic test_round_robin();
        int elapsed;
        logic [SRC_WIDTH-1:0]  expSrc;
        logic [DATA_WIDTH-1:0] expData;
        resetDut();
        for (int i = 0; i < PORTS; i++) remaining[i] = -1;
        elapsed = 0;
        while (outSrc.size() < 20 && elapsed < 60) begin
            cycle();
            elapsed++;
        end
        vectors++; if (outSrc.size() < 20) begin $display("[TB] FAIL rr_timeout: got %0d beats expected 20", outSrc.size()); miscompares++; end
        vectors++; if (elapsed != 26) begin $display("[TB] FAIL rr_cycles: got %0d expected 26", elapsed); miscompares++; end
        for (int j = 0; j < 20 && j < outSrc.size(); j++) begin
            expSrc  = SRC_WIDTH'((j / 4) % 4);
            expData = 8'(((j / 4) % 4) * 16 + (j / 16) * 4 + j % 4);
            vectors++; if (outSrc[j] !== expSrc) begin $display("[TB] FAIL rr_src[%0d]: got %0d expected %0d", j, outSrc[j], expSrc); miscompares++; end
            vectors++; if (outData[j] !== expData) begin $display("[TB] FAIL rr_data[%0d]: got %h expected %h", j, outData[j], expData); miscompares++; end
        end
        vectors++; if (accepted != delivered + int'(ovalid)) begin $display("[TB] FAIL rr_conservation: got %0d accepted expected %0d", accepted, delivered + int'(ovalid)); miscompares++; end
    endtask

    task automatic test_backpressure();
        logic [DATA_WIDTH-1:0] holdD;
        logic [SRC_WIDTH-1:0]  holdS;
        int stalls;
        resetDut();
        remaining[2] = 3;
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            oready = (c % 2 == 0);
            applyStimulus();
            if (ovalid && !oready) begin
                holdD = odata;
                holdS = osource;
                vectors++; if (iready !== 4'b0000) begin $display("[TB] FAIL bp_stall_iready: got %b expected 0000", iready); miscompares++; end
                vectors++; if (busy !== 1'b1) begin $display("[TB] FAIL bp_stall_busy: got %b expected 1", busy); miscompares++; end
                cycle();
                vectors++; if (ovalid !== 1'b1) begin $display("[TB] FAIL bp_hold_ovalid: got %b expected 1", ovalid); miscompares++; end
                vectors++; if (odata !== holdD) begin $display("[TB] FAIL bp_hold_odata: got %h expected %h", odata, holdD); miscompares++; end
                vectors++; if (osource !== holdS) begin $display("[TB] FAIL bp_hold_osource: got %0d expected %0d", osource, holdS); miscompares++; end
                stalls++;
            end else begin
                cycle();
            end
        end
        oready = 1'b1;
        vectors++; if (stalls != 2) begin $display("[TB] FAIL bp_stalls: got %0d expected 2", stalls); miscompares++; end
        vectors++; if (outData.size() != 3) begin $display("[TB] FAIL bp_count: got %0d expected 3", outData.size()); miscompares++; end
        for (int j = 0; j < 3 && j < outData.size(); j++) begin
            vectors++; if (outData[j] !== 8'(8'h20 + j) || outSrc[j] !== 2'd2) begin $display("[TB] FAIL bp_beat[%0d]: got %0d/%h expected 2/%h", j, outSrc[j], outData[j], 8'(8'h20 + j)); miscompares++; end
        end
        vectors++; if (busy !== 1'b0) begin $display("[TB] FAIL bp_release_busy: got %b expected 0", busy); miscompares++; end
    endtask

    task automatic test_idle_release();
        int expSrc[6]  = '{1, 1, 3, 3, 1, 1};
        int expData[6] = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h12, 8'h13};
        int bound;
        resetDut();
        remaining[1] = 2;
        remaining[3] = 2;
        bound = 0;
        while (remaining[1] != 0 && bound < 10) begin
            cycle();
            bound++;
        end
        vectors++; if (remaining[1] != 0) begin $display("[TB] FAIL idle_port1_timeout: got %0d left expected 0", remaining[1]); miscompares++; end
        cycle();
        vectors++; if (busy !== 1'b0) begin $display("[TB] FAIL idle_release_busy: got %b expected 0", busy); miscompares++; end
        remaining[1] = 2;
        cycle();
        applyStimulus();
        vectors++; if (iready !== 4'b1000) begin $display("[TB] FAIL idle_next_grant: got %b expected 1000", iready); miscompares++; end
        bound = 0;
        while (outSrc.size() < 6 && bound < 30) begin
            cycle();
            bound++;
        end
        vectors++; if (outSrc.size() < 6) begin $display("[TB] FAIL idle_timeout: got %0d beats expected 6", outSrc.size()); miscompares++; end
        for (int j = 0; j < 6 && j < outSrc.size(); j++) begin
            vectors++; if (outSrc[j] !== SRC_WIDTH'(expSrc[j]) || outData[j] !== 8'(expData[j])) begin $display("[TB] FAIL idle_beat[%0d]: got %0d/%h expected %0d/%h", j, outSrc[j], outData[j], expSrc[j], expData[j]); miscompares++; end
        end
    endtask

    task automatic test_reset_midburst();
        resetDut();
        for (int i = 0; i < PORTS; i++) remaining[i] = -1;
        repeat (3) cycle();
        vectors++; if (ovalid !== 1'b1) begin $display("[TB] FAIL mid_pre_ovalid: got %b expected 1", ovalid); miscompares++; end
        reset = 1'b1;
        cycle();
        applyStimulus();
        vectors++; if (ovalid !== 1'b0) begin $display("[TB] FAIL mid_ovalid: got %b expected 0", ovalid); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("[TB] FAIL mid_busy: got %b expected 0", busy); miscompares++; end
        vectors++; if (iready !== 4'b0000) begin $display("[TB] FAIL mid_iready: got %b expected 0000", iready); miscompares++; end
        reset = 1'b0;
        cycle();
        applyStimulus();
        vectors++; if (iready !== 4'b0001) begin $display("[TB] FAIL mid_priority: got %b expected 0001", iready); miscompares++; end
        cycle();
        vectors++; if (osource !== 2'd0 || odata !== 8'h02) begin $display("[TB] FAIL mid_first_beat: got %0d/%h expected 0/02", osource, odata); miscompares++; end
    endtask

`ifdef AXIS_ARB_LAST_EN
    task automatic test_packet_last();
        int elapsed;
        resetDut();
        remaining[0] = 7;
        remaining[1] = -1;
        elapsed = 0;
        while (outSrc.size() < 8 && elapsed < 40) begin
            cycle();
            elapsed++;
        end
        vectors++; if (elapsed != 11) begin $display("[TB] FAIL pkt_cycles: got %0d expected 11", elapsed); miscompares++; end
        for (int j = 0; j < 7 && j < outSrc.size(); j++) begin
            vectors++; if (outSrc[j] !== 2'd0 || outData[j] !== 8'(j) || outLast[j] !== (j == 6)) begin $display("[TB] FAIL pkt_beat[%0d]: got %0d/%h/%b expected 0/%h/%b", j, outSrc[j], outData[j], outLast[j], 8'(j), j == 6); miscompares++; end
        end
        if (outSrc.size() >= 8) begin
            vectors++; if (outSrc[7] !== 2'd1 || outData[7] !== 8'h10) begin $display("[TB] FAIL pkt_next: got %0d/%h expected 1/10", outSrc[7], outData[7]); miscompares++; end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AXIS_ARB_LAST_EN
        test_reset_midburst();
        test_packet_last();
`else
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_idle_release();
        test_reset_midburst();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI-stream sink, typically an axis_fifo write port, between PORTS AXI-stream requesters.
- Grants one requester at a time. The grant is held for a bounded burst, then rotates.
- Output is fully registered, so odata/ovalid/osource meet timing in front of the FIFO.
- Sits between the per-source stream producers and the shared FIFO/bus.

Parameters:
PORTS, 4, number of requesters (2..16)
DATA_WIDTH, 8, beat width
MAX_BURST, 4, max beats accepted per grant before forced rotation (1..255)
SRC_WIDTH, clog2(PORTS), width of source index

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
idata  in  PORTS*DATA_WIDTH  packed input beats, port i at [i*DATA_WIDTH +: DATA_WIDTH]
ivalid  in  PORTS  per-port valid
iready  out  PORTS  per-port ready
odata  out  DATA_WIDTH  registered output beat
ovalid  out  1  registered output valid
oready  in  1  sink ready
osource  out  SRC_WIDTH  port index that produced odata
busy  out  1  a grant is currently held

Behaviour:
- Reset (synchronous, active-high, sampled on clock):
  - ovalid=0, odata=0, osource=0, busy=0, iready=0.
  - State=IDLE, last-granted pointer=PORTS-1 (so port 0 has first priority), burst count=0.
  - Reset mid-burst drops the grant and the output beat. In-flight data is lost by design.
- Handshakes:
  - A transfer on port i occurs when ivalid[i] && iready[i].
  - An output transfer occurs when ovalid && oready.
  - Producers must not withdraw ivalid or change idata while valid and not ready. Same rule for odata/ovalid toward the sink.
- Output register:
  - Slot "can load" = !ovalid || oready.
  - iready[i] = (state==GRANT) && (grant==i) && can_load. At most one iready bit is high, and never while reset.
  - On an input transfer: odata<=idata[grant], osource<=grant, ovalid<=1.
  - Else on an output transfer: ovalid<=0.
  - Input and output transfers in the same cycle are allowed, giving full throughput of one beat per clock.
- FSM:
  - IDLE:
    - busy=0.
    - If any ivalid, pick the first port with ivalid set, searching cyclically from (last+1) mod PORTS.
    - Register it as grant; state<=GRANT; burst<=0.
    - Arbitration costs exactly one cycle. Request at cycle t gives iready at t+1 and ovalid at t+2 (if the sink is ready).
  - GRANT:
    - busy=1.
    - Each input transfer increments burst.
    - Go to IDLE with last<=grant when either:
      - a transfer makes burst reach MAX_BURST, or
      - can_load && !ivalid[grant] (the requester idles while the slot is free).
    - When !can_load the grant is held regardless of ivalid, so back-pressure alone never forces rotation.
- Fairness: with all ports requesting continuously, ports are served 0,1,..,PORTS-1,0,..., each taking exactly MAX_BURST beats.
- Conservation: beats accepted on all inputs = beats delivered + ovalid, at every cycle.
- Width rules:
  - burst counter is clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
  - Pointer arithmetic wraps mod PORTS, including non-power-of-two PORTS.
- Boundary cases:
  - Single requester: re-granted after one IDLE cycle. Throughput is MAX_BURST beats per MAX_BURST+1 cycles.
  - oready stuck low: ovalid, odata and osource are held stable, and all iready=0.

Optional Feature:
AXIS_ARB_LAST_EN:
- Defined:
  - Adds ports ilast (in, PORTS) and olast (out, 1). olast is registered alongside odata.
  - The grant is held until the beat with ilast[grant] transfers. MAX_BURST is ignored, and so is idle release.
  - Packets are never interleaved.
- Undefined: no last ports; rotation follows the MAX_BURST/idle rules above.

Decomposition:
- Package axis_pkg: state enum {IDLE, GRANT}, clog2 function, SRC_WIDTH derivation helper.
- Sub-module axis_rr_pick:
  - Purely combinational.
  - Inputs: request vector, last pointer. Outputs: any flag, winner index.
  - Reused by later schedulers.

Test Plan:
- Reset, then ivalid=4'b0001 on port 0, oready=1:
  - iready[0] rises 1 cycle later; first odata appears with osource=0 2 cycles after the request.
- All four ports valid continuously, MAX_BURST=4, oready=1:
  - osource sequence 0×4, 1×4, 2×4, 3×4, 0×4.
  - One bubble (ovalid=0) per rotation; no beat lost or duplicated.
- Port 2 valid alone, oready toggling 1,0,1,0:
  - Grant held through stalls; odata stable while ovalid && !oready; each beat accepted exactly once.
- Port 1 granted, drops ivalid after 2 beats while port 3 waits:
  - Grant moves to port 3 after one IDLE cycle; port 1 is not re-granted until port 3 is served.
- Reset asserted mid-burst with ovalid=1:
  - Next cycle ovalid=0, busy=0, all iready=0; after release, port 0 has priority.
- AXIS_ARB_LAST_EN, port 0 sends a 7-beat packet with ilast on beat 7 while port 1 requests:
  - All 7 beats go out contiguously with osource=0, olast on beat 7, then port 1 is granted.
